uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
- Receive-side stage that consumes the serial line produced by the team's 11-bit UART transmitter.
- Recovers the frame: start (0), D0..D7 LSB first, marker bit (1), parity bit.
- Presents the byte on a parallel port with a one-cycle valid pulse plus frame and parity status.
- Sits directly downstream of the transmitter's out_tx, in loopback or across a board link.

Parameters:
- CLKS_PER_BIT, 21, clk cycles per bit period; must match the transmitter baud counter (0..20); legal range >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (integer), offset from the start-bit edge to the start-bit sample point.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low
- rx  input  1  serial line; idle high; asynchronous to clk
- data_out  output  8  last received byte; holds until the next valid
- valid  output  1  one-cycle pulse when a complete frame has been received
- parity_err  output  1  qualified by valid; sampled parity bit != XOR of D0..D7
- frame_err  output  1  qualified by valid; sampled marker bit == 0
- busy  output  1  high while the FSM is outside IDLE

Behaviour:
- Synchronizer: rx passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1.
- Reset (rst==0 at a clk edge):
  - FSM goes to IDLE.
  - bit counter = 0; baud counter = 0; armed = 0.
  - data_out = 8'h00; valid = 0; parity_err = 0; frame_err = 0; busy = 0.
- FSM states: IDLE, START, DATA, MARK, PARITY, DONE.
- IDLE:
  - armed is set when rx_s==1.
  - If armed and rx_s==0: go to START, baud counter = 0.
  - A line held low continuously does not re-trigger; the line must return high first.
- START:
  - Baud counter increments. When it reaches HALF_BIT, sample rx_s.
  - If the sample is 1: false start; return to IDLE, no output.
  - If the sample is 0: baud counter = 0, bit counter = 0, go to DATA.
- DATA:
  - Sample when the baud counter == CLKS_PER_BIT-1, then clear the counter.
  - Sampled bit shifts into a shift register at the MSB, shifting right, so D0 ends in bit 0.
  - After the 8th sample (bit counter wraps 7->0), go to MARK.
- MARK: sample after CLKS_PER_BIT cycles; store mark_bit; go to PARITY.
- PARITY: sample after CLKS_PER_BIT cycles; store par_bit; go to DONE.
- DONE (exactly one cycle):
  - valid = 1.
  - data_out <= shift register.
  - parity_err <= par_bit ^ (^shift).
  - frame_err <= ~mark_bit.
  - Next state IDLE; armed = 0.
- Errors never suppress valid; the byte is always delivered. parity_err and frame_err hold until the next valid.
- Timing: with the default parameters, valid rises HALF_BIT + 10*CLKS_PER_BIT + 1 = 221 cycles after the START entry cycle.
- Back-to-back frames:
  - The next falling edge is accepted from IDLE once rx_s has been seen high.
  - The transmitter's idle gap of at least one bit after parity guarantees this.
- Reset mid-frame: the partial frame is discarded; no valid pulse.
- rx glitch during a data bit: only the sample point matters; no resynchronisation mid-frame.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start check, data, marker, parity) is the 2-of-3 majority of rx_s at counter values target-1, target, target+1. Decision and state transition happen at target+1, so total latency grows by 1 cycle. Requires CLKS_PER_BIT >= 6.
- Undefined: single sample at the target count, exactly as described in Behaviour.

Test Plan:
- Loopback from the transmitter, data_in=8'hA5, CLKS_PER_BIT=21 -> one valid pulse, data_out=8'hA5, parity_err=0, frame_err=0, busy low after DONE.
- Frames 8'h00, 8'hFF, 8'h01 sent back-to-back with minimum idle gap -> three valid pulses, bytes in order, no errors, no missed start.
- Hand-driven frame 8'h3C with the parity bit inverted -> valid, data_out=8'h3C, parity_err=1, frame_err=0.
- Hand-driven frame 8'h55 with marker bit 0 -> valid, data_out=8'h55, frame_err=1.
- rx low pulse of 5 cycles, then high -> START entered, false start at HALF_BIT, back to IDLE, no valid.
- rx held low for 300 cycles after reset -> at most one frame with frame_err=1, then no further valid until rx returns high. In a separate run, rst pulsed low during D3 of a frame -> no valid, all outputs 0, next clean frame 8'hC3 received correctly.

Source files
------------

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
//
// Receiver for the 11-bit UART frame produced by the companion transmitter:
//   start (0), D0..D7 LSB first, marker (1), parity (XOR of D0..D7).
// The recovered byte is presented on data_out with a one-cycle valid pulse.
// Frame and parity status are qualified by valid and hold until the next
// valid. Bytes are delivered even when an error flag is set.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 4; >= 6 with majority voting)
//   HALF_BIT      offset from the start-bit edge to the start-bit sample point
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   data_out    last received byte, holds until the next valid
//   valid       one-cycle pulse when a complete frame has been received
//   parity_err  sampled parity bit != XOR of D0..D7 (qualified by valid)
//   frame_err   sampled marker bit == 0 (qualified by valid)
//   busy        high while the receiver is outside IDLE
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit decision is the 2-of-3
//                        majority of rx_s at target-1, target, target+1, and
//                        the decision is taken at target+1 (one extra cycle of
//                        total latency). When undefined, a single sample is
//                        taken at the target count.
// ----------------------------------------------------------------------------
module uart_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 21,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);

`ifdef UART_RX_MAJORITY_EN
   // Decision one count after the nominal sample point; the counter reloads
   // to 1 so the bit period stays CLKS_PER_BIT cycles.
   localparam logic [CntW-1:0] StartDec  = CntW'(HALF_BIT + 1);
   localparam logic [CntW-1:0] BitDec    = CntW'(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntReload = CntW'(1);
`else
   localparam logic [CntW-1:0] StartDec  = CntW'(HALF_BIT);
   localparam logic [CntW-1:0] BitDec    = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntReload = CntW'(0);
`endif

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StMark,
      StParity,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic              rx_meta_q, rx_s_q;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              mark_q, mark_d;
   logic              armed_q, armed_d;
   logic [7:0]        data_out_q, data_out_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;

   logic              rx_s;
   logic              bit_val;
   logic              bit_tick;

   assign rx_s = rx_s_q;

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] is rx_s one cycle ago, hist_q[1] two cycles ago.
   logic [1:0] hist_q, hist_d;

   assign hist_d  = {hist_q[0], rx_s};
   assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   assign bit_val = rx_s;
`endif

   // End of a full bit period in DATA / MARK / PARITY.
   assign bit_tick = (cnt_q == BitDec);

   // -------------------------------------------------------------------------
   // State register (also holds synchronizer and datapath flops)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         rx_meta_q    <= 1'b1;
         rx_s_q       <= 1'b1;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         mark_q       <= 1'b0;
         armed_q      <= 1'b0;
         data_out_q   <= '0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_meta_q    <= rx;
         rx_s_q       <= rx_meta_q;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         mark_q       <= mark_d;
         armed_q      <= armed_d;
         data_out_q   <= data_out_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            // armed_q guarantees the line was seen high before this edge.
            if (armed_q && !rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == StartDec) begin
               state_d = bit_val ? StIdle : StData;
            end
         end
         StData: begin
            if (bit_tick && (bit_cnt_q == 3'd7)) begin
               state_d = StMark;
            end
         end
         StMark: begin
            if (bit_tick) begin
               state_d = StParity;
            end
         end
         StParity: begin
            if (bit_tick) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Datapath next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      mark_d       = mark_q;
      armed_d      = armed_q;
      data_out_d   = data_out_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (rx_s) begin
               armed_d = 1'b1;
            end
         end
         StStart: begin
            if (cnt_q == StartDec) begin
               cnt_d     = CntReload;
               bit_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (bit_tick) begin
               // LSB arrives first, so shifting in at the MSB leaves D0 in bit 0.
               shift_d   = {bit_val, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               cnt_d     = CntReload;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StMark: begin
            if (bit_tick) begin
               mark_d = bit_val;
               cnt_d  = CntReload;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StParity: begin
            if (bit_tick) begin
               // Result registers load as DONE is entered so that they are
               // already valid during the DONE cycle.
               data_out_d   = shift_q;
               parity_err_d = bit_val ^ (^shift_q);
               frame_err_d  = ~mark_q;
               cnt_d        = CntReload;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            // Force the line to be seen high again before the next start.
            armed_d = 1'b0;
            cnt_d   = '0;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      valid      = (state_q == StDone);
      busy       = (state_q != StIdle);
      data_out   = data_out_q;
      parity_err = parity_err_q;
      frame_err  = frame_err_q;
   end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Drives serial frames into uart_rx_frame and compares every valid pulse
// against frames predicted from the transmitted bits: data = sent byte,
// parity_err = (sent parity bit != XOR of byte), frame_err = (sent marker == 0).
// ----------------------------------------------------------------------------
module tb_uart_rx_frame;

   localparam int unsigned C = 21;
   localparam int unsigned H = C / 2;
   // rx edge -> two synchronizer flops -> IDLE detect edge -> START entry.
`ifdef UART_RX_MAJORITY_EN
   localparam int unsigned ExpLatency = 3 + H + 10 * C + 2;
`else
   localparam int unsigned ExpLatency = 3 + H + 10 * C + 1;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } frm_t;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int   checks;
   int   errors;
   int   cyc;
   frm_t exp_q[$];
   frm_t got_q[$];
   int   got_cyc[$];

   uart_rx_frame #(
      .CLKS_PER_BIT(C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data_out  (data_out),
      .valid     (valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every valid cycle away from the active edge.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         got_q.push_back(frm_t'{data_out, parity_err, frame_err});
         got_cyc.push_back(cyc);
      end
   end

   // Hold rx at b for n clock cycles; rx always changes 1 ns after a posedge.
   task automatic drive_bits(input logic b, input int n);
      rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send one frame and record what the receiver must report for it.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic mark,
                             input int gap_bits);
      frm_t f;
      f.d  = d;
      f.pe = par ^ (^d);
      f.fe = ~mark;
      exp_q.push_back(f);
      drive_bits(1'b0, C);
      for (int i = 0; i < 8; i++) drive_bits(d[i], C);
      drive_bits(mark, C);
      drive_bits(par, C);
      drive_bits(1'b1, gap_bits * C);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rx  = 1'b1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b1;
      drive_bits(1'b1, 2 * C);
   endtask

   task automatic test_loopback();
      int fall_cyc;
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      fall_cyc = cyc;
      send_frame(8'hA5, ^8'hA5, 1'b1, 2);
      checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL loop_count got %0d want 1", got_q.size()); end
      if (got_q.size() >= 1) begin
         checks++;
         if (got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL loop_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                     got_q[0].d, got_q[0].pe, got_q[0].fe, exp_q[0].d, exp_q[0].pe, exp_q[0].fe);
         end
         checks++;
         if (got_cyc[0] - fall_cyc !== ExpLatency) begin
            errors++;
            $display("FAIL loop_latency got %0d want %0d", got_cyc[0] - fall_cyc, ExpLatency);
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy got %b want 0", busy); end
      checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL loop_hold got %h want a5", data_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      send_frame(8'h00, 1'b0, 1'b1, 1);
      send_frame(8'hFF, 1'b0, 1'b1, 1);
      send_frame(8'h01, 1'b1, 1'b1, 1);
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         send_frame(d, ^d, 1'b1, int'($urandom_range(1, 3)));
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL b2b_frame[%0d] got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", i,
                     got_q[i].d, got_q[i].pe, got_q[i].fe, exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
         end
      end
      checks++;
      if (data_out !== exp_q[exp_q.size() - 1].d) begin
         errors++; $display("FAIL b2b_hold got %h want %h", data_out, exp_q[exp_q.size() - 1].d);
      end
   endtask

   task automatic test_errors();
      logic [7:0] d;
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      send_frame(8'h3C, ~(^8'h3C), 1'b1, 2);
      send_frame(8'h55, ^8'h55, 1'b0, 2);
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         send_frame(d, (^d) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      end
      // End on the marker-error frame so the reset test sees non-zero status.
      send_frame(8'h55, ~(^8'h55), 1'b0, 2);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL err_count got %0d want %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL err_frame[%0d] got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b", i,
                     got_q[i].d, got_q[i].pe, got_q[i].fe, exp_q[i].d, exp_q[i].pe, exp_q[i].fe);
         end
      end
      checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL err_hold_pe got %b want 1", parity_err); end
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL err_hold_fe got %b want 1", frame_err); end
   endtask

   task automatic test_false_start();
      bit saw_busy;
      got_q.delete(); got_cyc.delete();
      saw_busy = 1'b0;
      rx = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); if (busy === 1'b1) saw_busy = 1'b1;
      end
      @(posedge clk); #1;
      rx = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); if (busy === 1'b1) saw_busy = 1'b1;
      end
      drive_bits(1'b1, 2 * C);
      checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL fs_start got busy_seen=%b want 1", saw_busy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_idle got %b want 0", busy); end
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL fs_novalid got %0d want 0", got_q.size()); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h5A;
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      drive_bits(1'b0, C);
      for (int i = 0; i < 3; i++) drive_bits(d[i], C);
      drive_bits(d[3], C / 2);
      rx = 1'b1;
      pulse_reset();
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got %h want 00", data_out); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL mid_perr got %b want 0", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_ferr got %b want 0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
      drive_bits(1'b1, 12 * C);
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_novalid got %0d want 0", got_q.size()); end
      send_frame(8'hC3, ^8'hC3, 1'b1, 2);
      checks++;
      if (got_q.size() !== 1) begin
         errors++; $display("FAIL mid_next_count got %0d want 1", got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL mid_next_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                  got_q[0].d, got_q[0].pe, got_q[0].fe, exp_q[0].d, exp_q[0].pe, exp_q[0].fe);
      end
   endtask

   task automatic test_held_low();
      exp_q.delete(); got_q.delete(); got_cyc.delete();
      rx = 1'b0;
      pulse_reset();
      repeat (300) @(posedge clk);
      #1;
      checks++; if (got_q.size() > 1) begin errors++; $display("FAIL low_count got %0d want <=1", got_q.size()); end
      if (got_q.size() == 1) begin
         checks++; if (got_q[0].fe !== 1'b1) begin errors++; $display("FAIL low_ferr got %b want 1", got_q[0].fe); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL low_busy got %b want 0", busy); end
      drive_bits(1'b1, 3 * C);
      got_q.delete(); got_cyc.delete();
      send_frame(8'h96, ^8'h96, 1'b1, 2);
      checks++;
      if (got_q.size() !== 1) begin
         errors++; $display("FAIL low_recover_count got %0d want 1", got_q.size());
      end else if (got_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL low_recover_frame got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                  got_q[0].d, got_q[0].pe, got_q[0].fe, exp_q[0].d, exp_q[0].pe, exp_q[0].fe);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rx     = 1'b1;
      rst    = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_loopback();
      test_back_to_back();
      test_errors();
      test_reset_mid_frame();
      test_false_start();
      test_held_low();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
